alu_ctrl_stage: RTL and testbench
=================================

Name: alu_ctrl_stage

Overview:
- Decode/issue stage that drives the ALU's inputs: 4-bit ALU control code, operand A, operand B and an overflow-check flag.
- Takes a decoded MIPS instruction (opcode, funct, rs/rt values, imm16) over valid/ready and presents it to the ALU stage over valid/ready.
- Registered, with a 2-entry skid buffer, so backpressure from the execute stage never creates a combinational ready path.

Parameters:
- DATA_W, 32, operand width; must be ≥16 for immediate extension.
- IMM_W, 16, immediate field width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept.
- opcode  in  6  instruction [31:26].
- funct  in  6  instruction [5:0].
- rs_val  in  DATA_W  register rs value.
- rt_val  in  DATA_W  register rt value.
- imm  in  IMM_W  instruction [15:0].
- out_valid  out  1  ALU inputs valid.
- out_ready  in  1  execute stage accepts.
- alu_control  out  4  ALU op code.
- alu_a  out  DATA_W  ALU operand A.
- alu_b  out  DATA_W  ALU operand B.
- ovf_chk  out  1  execute stage must trap on ALU overflow.
- illegal  out  1  unsupported opcode/funct.

Behaviour:
- Control codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 XOR, 1111 PASS (ALU outputs A).
- R-type (opcode 0x00), A=rs, B=rt:
  - funct 0x20 → 0010, ovf_chk=1; 0x21 → 0010, ovf_chk=0.
  - funct 0x22 → 0110, ovf_chk=1; 0x23 → 0110, ovf_chk=0.
  - funct 0x24 → 0000; 0x25 → 0001; 0x26 → 1100; 0x2A → 0111.
- I-type, A=rs:
  - Sign-extended imm: 0x08 addi → 0010, ovf_chk=1; 0x09 addiu → 0010; 0x0A slti → 0111; 0x23 lw, 0x2B sw → 0010.
  - Zero-extended imm: 0x0C → 0000; 0x0D → 0001; 0x0E → 1100.
- beq 0x04 / bne 0x05: 0110, A=rs, B=rt.
- lui 0x0F: 1111, A={imm,16'b0}, B=0.
- Any other opcode/funct: illegal=1, 1111, A=rs, B=0, ovf_chk=0.
- Sign extension replicates imm[IMM_W-1] up to DATA_W.
- Datapath: decode is combinational on the inputs; the result is captured into the output register on accept (in_valid && in_ready).
  - Latency 1 cycle: accepted in cycle N → out_valid in cycle N+1.
  - Throughput 1 per cycle while out_ready=1.
- Skid buffer: output register plus one skid register.
  - in_ready is registered and equals !skid_full.
  - Accept while output is full and not draining → entry goes to skid; skid moves to output on the next drain.
  - Order is strictly FIFO.
- Simultaneous drain + accept with skid empty: the output register reloads with the new entry, no bubble.
- Outputs hold stable while out_valid && !out_ready.
- flush: clears both entries next edge; out_valid=0, in_ready=1. An in_valid in the flush cycle is discarded. flush has priority over accept and drain.
- Reset values: out_valid=0, in_ready=1, alu_control=1111, alu_a=0, alu_b=0, ovf_chk=0, illegal=0.
- Reset mid-transfer discards all entries.

Optional Feature:
- Macro ALU_CTRL_ILLEGAL_DROP_EN.
- Defined:
  - Illegal instructions are accepted but never enter the buffer.
  - Adds output illegal_seen (1 bit, sticky): set the cycle after an illegal accept, cleared only by reset.
  - The illegal output is tied 0.
- Undefined: illegal instructions are forwarded with illegal=1 as described above; no illegal_seen port.

Test Plan:
- Reset → out_valid=0, in_ready=1, alu_control=1111; add (op 0x00, funct 0x20, rs=5, rt=7) accepted → next cycle alu_control=0010, A=5, B=7, ovf_chk=1.
- addi with rs=0x10, imm=0xFFFF → alu_control=0010, B=0xFFFFFFFF; ori with imm=0xFFFF → alu_control=0001, B=0x0000FFFF.
- lui with imm=0x1234 → alu_control=1111, A=0x12340000, B=0; funct 0x3F on opcode 0 → illegal=1, code 1111 (with macro: not forwarded, illegal_seen=1).
- Hold out_ready=0, issue 3 back-to-back ops (and, or, slt) → first held at output, second in skid, in_ready=0 in cycle 3. Release → outputs 0000, 0001, 0111 in consecutive cycles with no loss.
- Full buffer + flush while in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed-cycle instruction never appears.
- rst_n low while the skid is full → immediate out_valid=0, in_ready=1; after release, the first new op appears with 1-cycle latency.

Source files
------------

// File: rtl/alu_ctrl_stage.sv
// Decode/issue stage: turns a decoded MIPS instruction into ALU control, operands and overflow-check flag.
// Optional build macro ALU_CTRL_ILLEGAL_DROP_EN: drop illegal instructions and flag them on a sticky illegal_seen.
module alu_ctrl_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic [IMM_W-1:0]  imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        alu_control,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              ovf_chk,
`ifdef ALU_CTRL_ILLEGAL_DROP_EN
    output logic              illegal_seen,
`endif
    output logic              illegal
);

    localparam int unsigned EXT_W = DATA_W - IMM_W;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1100;
    localparam logic [3:0] OP_PASS = 4'b1111;

    typedef struct packed {
        logic [3:0]        ctrl;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              ovf;
        logic              ill;
    } entry_t;

    localparam entry_t RST_ENTRY = '{ctrl: OP_PASS, a: '0, b: '0, ovf: 1'b0, ill: 1'b0};

    entry_t            dec;
    entry_t            out_q, out_n, skid_q, skid_n;
    logic              out_v_q, out_v_n, skid_v_q, skid_v_n;
    logic              in_ready_q;
    logic              accept, enq, drain;
    logic [DATA_W-1:0] imm_sx, imm_zx;

    assign imm_sx = {{EXT_W{imm[IMM_W-1]}}, imm};
    assign imm_zx = {{EXT_W{1'b0}}, imm};

    // Instruction decode, purely combinational on the inputs
    always_comb begin
        dec = '{ctrl: OP_PASS, a: rs_val, b: '0, ovf: 1'b0, ill: 1'b0};
        case (opcode)
            6'h00: begin
                dec.b = rt_val;
                case (funct)
                    6'h20: begin dec.ctrl = OP_ADD; dec.ovf = 1'b1; end
                    6'h21: dec.ctrl = OP_ADD;
                    6'h22: begin dec.ctrl = OP_SUB; dec.ovf = 1'b1; end
                    6'h23: dec.ctrl = OP_SUB;
                    6'h24: dec.ctrl = OP_AND;
                    6'h25: dec.ctrl = OP_OR;
                    6'h26: dec.ctrl = OP_XOR;
                    6'h2A: dec.ctrl = OP_SLT;
                    default: begin dec.ill = 1'b1; dec.b = '0; end
                endcase
            end
            6'h08: begin dec.ctrl = OP_ADD; dec.b = imm_sx; dec.ovf = 1'b1; end
            6'h09: begin dec.ctrl = OP_ADD; dec.b = imm_sx; end
            6'h0A: begin dec.ctrl = OP_SLT; dec.b = imm_sx; end
            6'h23,
            6'h2B: begin dec.ctrl = OP_ADD; dec.b = imm_sx; end
            6'h0C: begin dec.ctrl = OP_AND; dec.b = imm_zx; end
            6'h0D: begin dec.ctrl = OP_OR;  dec.b = imm_zx; end
            6'h0E: begin dec.ctrl = OP_XOR; dec.b = imm_zx; end
            6'h04,
            6'h05: begin dec.ctrl = OP_SUB; dec.b = rt_val; end
            6'h0F: begin dec.a = DATA_W'({imm, 16'b0}); end
            default: dec.ill = 1'b1;
        endcase
    end

    assign accept = in_valid && in_ready_q && !flush;
    assign drain  = out_v_q && out_ready;
`ifdef ALU_CTRL_ILLEGAL_DROP_EN
    assign enq = accept && !dec.ill;
`else
    assign enq = accept;
`endif

    // Output register + skid register; the skid only fills when the output is stalled
    always_comb begin
        out_n    = out_q;
        out_v_n  = out_v_q;
        skid_n   = skid_q;
        skid_v_n = skid_v_q;
        if (flush) begin
            out_v_n  = 1'b0;
            skid_v_n = 1'b0;
        end else if (drain) begin
            if (skid_v_q) begin
                out_n = skid_q;
                if (enq) begin
                    skid_n = dec;
                end else begin
                    skid_v_n = 1'b0;
                end
            end else if (enq) begin
                out_n = dec;
            end else begin
                out_v_n = 1'b0;
            end
        end else if (!out_v_q) begin
            if (enq) begin
                out_n   = dec;
                out_v_n = 1'b1;
            end
        end else if (enq) begin
            skid_n   = dec;
            skid_v_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= RST_ENTRY;
            out_v_q    <= 1'b0;
            skid_q     <= RST_ENTRY;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            out_q      <= out_n;
            out_v_q    <= out_v_n;
            skid_q     <= skid_n;
            skid_v_q   <= skid_v_n;
            in_ready_q <= !skid_v_n;
        end
    end

`ifdef ALU_CTRL_ILLEGAL_DROP_EN
    logic seen_q;

    // Sticky record of any dropped illegal instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= 1'b0;
        end else if (accept && dec.ill) begin
            seen_q <= 1'b1;
        end
    end

    assign illegal_seen = seen_q;
    assign illegal      = 1'b0;
`else
    assign illegal = out_q.ill;
`endif

    assign in_ready    = in_ready_q;
    assign out_valid   = out_v_q;
    assign alu_control = out_q.ctrl;
    assign alu_a       = out_q.a;
    assign alu_b       = out_q.b;
    assign ovf_chk     = out_q.ovf;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed bench for alu_ctrl_stage: decode table, skid buffering, flush and async reset.
module tb_alu_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [15:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_control;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        ovf_chk;
    logic        illegal;
`ifdef ALU_CTRL_ILLEGAL_DROP_EN
    logic        illegal_seen;
`endif

    int checks = 0;
    int errors = 0;

    alu_ctrl_stage #(.DATA_W(32), .IMM_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .funct       (funct),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .imm         (imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_control (alu_control),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .ovf_chk     (ovf_chk),
`ifdef ALU_CTRL_ILLEGAL_DROP_EN
        .illegal_seen(illegal_seen),
`endif
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] im);
        in_valid = v;
        opcode   = op;
        funct    = fn;
        rs_val   = rs;
        rt_val   = rt;
        imm      = im;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                           input logic [31:0] b, input logic ovf);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".ctrl"},  32'(alu_control), 32'(ctrl));
        chk({tag, ".a"},     alu_a, a);
        chk({tag, ".b"},     alu_b, b);
        chk({tag, ".ovf"},   32'(ovf_chk), 32'(ovf));
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0, 16'h0);
        #12;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.ready", 32'(in_ready), 32'd1);
        chk("rst.ctrl",  32'(alu_control), 32'hF);
        chk("rst.a",     alu_a, 32'h0);
        chk("rst.b",     alu_b, 32'h0);
        chk("rst.ovf",   32'(ovf_chk), 32'd0);
        chk("rst.ill",   32'(illegal), 32'd0);
        tick();
        rst_n = 1'b1;

        // Decode table, one instruction per cycle with the sink always ready
        drive(1'b1, 6'h00, 6'h20, 32'd5, 32'd7, 16'h0);
        tick(); chk_out("add", 4'b0010, 32'd5, 32'd7, 1'b1);
        chk("add.ready", 32'(in_ready), 32'd1);
        drive(1'b1, 6'h08, 6'h00, 32'h10, 32'h99, 16'hFFFF);
        tick(); chk_out("addi", 4'b0010, 32'h10, 32'hFFFFFFFF, 1'b1);
        drive(1'b1, 6'h0D, 6'h00, 32'h10, 32'h99, 16'hFFFF);
        tick(); chk_out("ori", 4'b0001, 32'h10, 32'h0000FFFF, 1'b0);
        drive(1'b1, 6'h0F, 6'h00, 32'h77, 32'h99, 16'h1234);
        tick(); chk_out("lui", 4'b1111, 32'h12340000, 32'h0, 1'b0);
        drive(1'b1, 6'h00, 6'h23, 32'd3, 32'd1, 16'h0);
        tick(); chk_out("subu", 4'b0110, 32'd3, 32'd1, 1'b0);
        drive(1'b1, 6'h04, 6'h00, 32'hA, 32'hB, 16'h5);
        tick(); chk_out("beq", 4'b0110, 32'hA, 32'hB, 1'b0);
        drive(1'b1, 6'h0A, 6'h00, 32'h1, 32'h2, 16'h8000);
        tick(); chk_out("slti", 4'b0111, 32'h1, 32'hFFFF8000, 1'b0);
        drive(1'b1, 6'h0E, 6'h00, 32'h1, 32'h2, 16'h8000);
        tick(); chk_out("xori", 4'b1100, 32'h1, 32'h00008000, 1'b0);
        drive(1'b1, 6'h2B, 6'h00, 32'h40, 32'h2, 16'h0004);
        tick(); chk_out("sw", 4'b0010, 32'h40, 32'h4, 1'b0);
        chk("sw.ill", 32'(illegal), 32'd0);
        drive(1'b1, 6'h00, 6'h3F, 32'd9, 32'd4, 16'h0);
        tick();
`ifdef ALU_CTRL_ILLEGAL_DROP_EN
        chk("ill.valid", 32'(out_valid), 32'd0);
        chk("ill.seen",  32'(illegal_seen), 32'd1);
`else
        chk_out("ill", 4'b1111, 32'd9, 32'd0, 1'b0);
        chk("ill.flag", 32'(illegal), 32'd1);
`endif
        drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0, 16'h0);
        tick(); chk("idle.valid", 32'(out_valid), 32'd0);

        // Backpressure: and held at output, or in skid, slt stalled
        out_ready = 1'b0;
        drive(1'b1, 6'h00, 6'h24, 32'd1, 32'd2, 16'h0);
        tick(); chk_out("bp.and0", 4'b0000, 32'd1, 32'd2, 1'b0);
        chk("bp.ready1", 32'(in_ready), 32'd1);
        drive(1'b1, 6'h00, 6'h25, 32'd3, 32'd4, 16'h0);
        tick(); chk_out("bp.hold1", 4'b0000, 32'd1, 32'd2, 1'b0);
        chk("bp.ready2", 32'(in_ready), 32'd0);
        drive(1'b1, 6'h00, 6'h2A, 32'd5, 32'd6, 16'h0);
        tick(); chk_out("bp.hold2", 4'b0000, 32'd1, 32'd2, 1'b0);
        chk("bp.ready3", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick(); chk_out("bp.or", 4'b0001, 32'd3, 32'd4, 1'b0);
        chk("bp.ready4", 32'(in_ready), 32'd1);
        tick(); chk_out("bp.slt", 4'b0111, 32'd5, 32'd6, 1'b0);
        drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0, 16'h0);
        tick(); chk("bp.empty", 32'(out_valid), 32'd0);

        // Flush a full buffer while a new instruction is offered
        out_ready = 1'b0;
        drive(1'b1, 6'h00, 6'h26, 32'd1, 32'd1, 16'h0);
        tick();
        drive(1'b1, 6'h00, 6'h21, 32'd2, 32'd2, 16'h0);
        tick(); chk("fl.full", 32'(in_ready), 32'd0);
        flush = 1'b1;
        drive(1'b1, 6'h00, 6'h22, 32'd8, 32'd8, 16'h0);
        tick(); chk("fl.valid", 32'(out_valid), 32'd0);
        chk("fl.ready", 32'(in_ready), 32'd1);
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0, 16'h0);
        tick(); chk("fl.gone", 32'(out_valid), 32'd0);

        // Asynchronous reset while the skid is full
        out_ready = 1'b0;
        drive(1'b1, 6'h00, 6'h24, 32'd1, 32'd2, 16'h0);
        tick();
        drive(1'b1, 6'h00, 6'h25, 32'd3, 32'd4, 16'h0);
        tick(); chk("ar.full", 32'(in_ready), 32'd0);
        drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0, 16'h0);
        rst_n = 1'b0;
        #1;
        chk("ar.valid", 32'(out_valid), 32'd0);
        chk("ar.ready", 32'(in_ready), 32'd1);
        chk("ar.ctrl",  32'(alu_control), 32'hF);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 6'h00, 6'h20, 32'd5, 32'd7, 16'h0);
        tick(); chk_out("ar.add", 4'b0010, 32'd5, 32'd7, 1'b1);
        drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0, 16'h0);
        tick(); chk("ar.drained", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
